qdrc_phy_cal_sequencer: RTL and testbench
=========================================

# qdrc_phy_cal_sequencer

Top-level calibration sequencer for the QDR PHY read path. After PHY clocking is ready it enables the training-pattern loop, then resets and starts the per-bit IODELAY trainer. It retries training up to a bounded count, then runs burst (half-word) alignment and reports a single calibrated/failed status to the QDR controller core. It sits between the clock/IDELAYCTRL ready logic, the pattern generator, the bit trainer and the burst aligner.

## Interface
Parameters:
- SETTLE_CYCLES, 1024: wait after phy_ready before pattern enable; range 1..65535.
- TIMEOUT_CYCLES, 65536: maximum cycles allowed per handshake phase (PATTERN, TRAIN, ALIGN); range 1..2^20-1.
- MAX_RETRY, 3: extra bit-train attempts after the first failure; range 0..15.

Ports:
- clk, in, 1: controller clock.
- reset, in, 1: synchronous, active-high.
- phy_ready, in, 1: PLL locked AND IDELAYCTRL ready, synchronous to clk.
- cal_start, in, 1: level; calibration begins when high in IDLE.
- pat_en, out, 1: enables the training-pattern write/read loop.
- pat_ack, in, 1: level; pattern loop is running.
- bt_reset, out, 1: reset to the bit trainer, which also resets its IODELAYs.
- bt_start, out, 1: level start to the bit trainer.
- bt_done, in, 1: bit trainer done (sticky until bt_reset).
- bt_fail, in, 1: bit trainer fail flag.
- al_start, out, 1: level start to the burst aligner.
- al_done, in, 1: burst aligner done.
- al_fail, in, 1: burst aligner fail flag.
- cal_done, out, 1: calibration finished successfully.
- cal_fail, out, 1: calibration finished with failure.
- retry_count, out, 4: number of bit-train retries consumed.
- err_prb, out, 3: error code.
- state_prb, out, 4: current state encoding.

## Operation
- States and encodings: IDLE=0, WAIT_READY=1, SETTLE=2, PATTERN=3, TRAIN_RST=4, TRAIN=5, ALIGN=6, DONE=7, FAIL=8.
- Timer: one 20-bit counter. It is cleared on every state entry and increments every cycle while in SETTLE, TRAIN_RST, PATTERN, TRAIN and ALIGN.
- IDLE
  - Outputs: bt_reset=1, everything else 0.
  - cal_start=1 -> WAIT_READY; clears retry_count and err_prb.
- WAIT_READY
  - bt_reset=1.
  - phy_ready=1 -> SETTLE.
- SETTLE
  - bt_reset=1.
  - Timer reaches SETTLE_CYCLES-1 -> PATTERN.
- PATTERN
  - pat_en=1, bt_reset=1.
  - pat_ack=1 -> TRAIN_RST.
  - Timer reaches TIMEOUT_CYCLES-1 -> FAIL with err=1 (NO_PATTERN).
- TRAIN_RST
  - pat_en=1, bt_reset=1 for exactly 4 cycles -> TRAIN.
- TRAIN
  - pat_en=1, bt_start=1, bt_reset=0.
  - bt_done=1 and bt_fail=0 -> ALIGN.
  - bt_done=1 and bt_fail=1 is a train failure.
  - Timer reaches TIMEOUT_CYCLES-1 without bt_done is a train failure, recorded as err=3 (TRAIN_TIMEOUT).
  - On a train failure with retry_count < MAX_RETRY: retry_count+1, err=2 (TRAIN_FAIL) unless the failure was a timeout, -> TRAIN_RST.
  - On a train failure otherwise -> FAIL; err keeps its last code.
  - If bt_done and timer expiry occur in the same cycle, bt_done wins.
- ALIGN
  - pat_en=1, bt_start=1 (held so the trainer stays done), al_start=1.
  - al_done=1 and al_fail=0 -> DONE.
  - al_done=1 and al_fail=1 -> FAIL with err=4 (ALIGN_FAIL).
  - Timeout -> FAIL with err=5 (ALIGN_TIMEOUT).
  - No retries in this state.
- DONE
  - cal_done=1, pat_en=0.
  - bt_start and al_start stay 1 so the trainer and aligner hold their results.
  - Stays here until reset or loss of phy_ready.
- FAIL
  - cal_fail=1, pat_en=0, bt_reset=1.
  - Stays here until reset.
  - cal_start does not restart calibration from FAIL.
- Loss of ready:
  - phy_ready=0 in any state except IDLE, WAIT_READY or FAIL -> WAIT_READY next cycle.
  - Clears cal_done, retry_count and err_prb, drops all starts and asserts bt_reset.
  - This takes priority over every other transition.
- retry_count saturates at MAX_RETRY and never wraps.

## Timing
- All outputs are registered and change one cycle after the causing input or state edge.
- Reset values: bt_reset=1; pat_en, bt_start, al_start, cal_done, cal_fail=0; retry_count=0; err_prb=0; state_prb=0.
- Reset mid-operation returns to IDLE on the next edge and discards any in-progress handshake.
- bt_reset pulse between training attempts is exactly 4 cycles.
- First bt_start rises SETTLE_CYCLES+5 cycles after phy_ready rises, given pat_ack=1 immediately: 1 (WAIT_READY exit) + SETTLE_CYCLES + 1 (PATTERN) + 4 (TRAIN_RST) - 1 (overlap).
- cal_done rises 1 cycle after al_done is sampled high in ALIGN.
- cal_done and cal_fail are mutually exclusive and are never high at the same time.

## Test plan
- Nominal: phy_ready=1, cal_start pulse, pat_ack 10 cycles after pat_en, bt_done with bt_fail=0 after 500 cycles, al_done after 50 cycles -> cal_done=1, retry_count=0, err_prb=0, state_prb=7.
- Retry: with MAX_RETRY=3, bt_fail=1 on the first two attempts and success on the third -> two 4-cycle bt_reset pulses, retry_count=2, cal_done=1.
- Exhaustion: bt_fail=1 on every attempt -> 4 attempts total, retry_count=3, cal_fail=1, err_prb=2, state_prb=8, bt_reset=1.
- Timeouts: with TIMEOUT_CYCLES=100 and pat_ack held 0 -> FAIL with err_prb=1 at cycle 100 of PATTERN. With bt_done held 0 and MAX_RETRY=0 -> FAIL with err_prb=3.
- phy_ready drops during TRAIN and in DONE -> state WAIT_READY next cycle, cal_done=0, bt_start=0, bt_reset=1. When phy_ready returns, the full sequence reruns.
- reset asserted during ALIGN -> next cycle state_prb=0, al_start=0, bt_reset=1. bt_done and al_done arriving simultaneously with reset are ignored.

Source files
------------

// File: rtl/qdrc_phy_cal_sequencer.sv
// QDR PHY read-path calibration sequencer. It runs settle, pattern loop, bit training
// with bounded retries and burst alignment, then reports a single calibrated or failed status.
module qdrc_phy_cal_sequencer #(
  parameter int unsigned SETTLE_CYCLES  = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 65536,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       phy_ready,
  input  logic       cal_start,
  output logic       pat_en,
  input  logic       pat_ack,
  output logic       bt_reset,
  output logic       bt_start,
  input  logic       bt_done,
  input  logic       bt_fail,
  output logic       al_start,
  input  logic       al_done,
  input  logic       al_fail,
  output logic       cal_done,
  output logic       cal_fail,
  output logic [3:0] retry_count,
  output logic [2:0] err_prb,
  output logic [3:0] state_prb
);

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_WAIT_READY = 4'd1,
    ST_SETTLE     = 4'd2,
    ST_PATTERN    = 4'd3,
    ST_TRAIN_RST  = 4'd4,
    ST_TRAIN      = 4'd5,
    ST_ALIGN      = 4'd6,
    ST_DONE       = 4'd7,
    ST_FAIL       = 4'd8
  } state_t;

  localparam logic [19:0] SETTLE_LAST  = 20'(SETTLE_CYCLES - 1);
  localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYCLES - 1);
  localparam logic [19:0] TRST_LAST    = 20'd3;
  localparam logic [3:0]  RETRY_MAX    = 4'(MAX_RETRY);

  localparam logic [2:0] ERR_NONE          = 3'd0;
  localparam logic [2:0] ERR_NO_PATTERN    = 3'd1;
  localparam logic [2:0] ERR_TRAIN_FAIL    = 3'd2;
  localparam logic [2:0] ERR_TRAIN_TIMEOUT = 3'd3;
  localparam logic [2:0] ERR_ALIGN_FAIL    = 3'd4;
  localparam logic [2:0] ERR_ALIGN_TIMEOUT = 3'd5;

  state_t      state_q, state_d;
  logic [19:0] timer_q, timer_d;
  logic [3:0]  retry_q, retry_d;
  logic [2:0]  err_q, err_d;
  logic        pat_en_q, pat_en_d;
  logic        bt_reset_q, bt_reset_d;
  logic        bt_start_q, bt_start_d;
  logic        al_start_q, al_start_d;
  logic        cal_done_q, cal_done_d;
  logic        cal_fail_q, cal_fail_d;
  logic        timed_out;
  logic        timer_runs;

  always_comb begin
    state_d    = state_q;
    retry_d    = retry_q;
    err_d      = err_q;
    timed_out  = (timer_q == TIMEOUT_LAST);
    timer_runs = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cal_start) begin
          state_d = ST_WAIT_READY;
          retry_d = 4'd0;
          err_d   = ERR_NONE;
        end
      end
      ST_WAIT_READY: begin
        if (phy_ready) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        timer_runs = 1'b1;
        if (timer_q == SETTLE_LAST) state_d = ST_PATTERN;
      end
      ST_PATTERN: begin
        timer_runs = 1'b1;
        if (pat_ack) begin
          state_d = ST_TRAIN_RST;
        end else if (timed_out) begin
          state_d = ST_FAIL;
          err_d   = ERR_NO_PATTERN;
        end
      end
      ST_TRAIN_RST: begin
        timer_runs = 1'b1;
        if (timer_q == TRST_LAST) state_d = ST_TRAIN;
      end
      ST_TRAIN: begin
        timer_runs = 1'b1;
        // bt_done takes precedence over a timeout landing in the same cycle
        if (bt_done && !bt_fail) begin
          state_d = ST_ALIGN;
        end else if (bt_done || timed_out) begin
          if (!bt_done) err_d = ERR_TRAIN_TIMEOUT;
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 4'd1;
            if (bt_done) err_d = ERR_TRAIN_FAIL;
            state_d = ST_TRAIN_RST;
          end else begin
            state_d = ST_FAIL;
          end
        end
      end
      ST_ALIGN: begin
        timer_runs = 1'b1;
        if (al_done) begin
          if (al_fail) begin
            state_d = ST_FAIL;
            err_d   = ERR_ALIGN_FAIL;
          end else begin
            state_d = ST_DONE;
          end
        end else if (timed_out) begin
          state_d = ST_FAIL;
          err_d   = ERR_ALIGN_TIMEOUT;
        end
      end
      ST_DONE: state_d = ST_DONE;
      ST_FAIL: state_d = ST_FAIL;
      default: state_d = ST_IDLE;
    endcase

    // Losing clocks invalidates every trained result, so start over from WAIT_READY
    if (!phy_ready && state_q != ST_IDLE && state_q != ST_WAIT_READY && state_q != ST_FAIL) begin
      state_d = ST_WAIT_READY;
      retry_d = 4'd0;
      err_d   = ERR_NONE;
    end

    if (state_d != state_q) timer_d = 20'd0;
    else if (timer_runs)    timer_d = timer_q + 20'd1;
    else                    timer_d = timer_q;

    pat_en_d   = 1'b0;
    bt_reset_d = 1'b0;
    bt_start_d = 1'b0;
    al_start_d = 1'b0;
    cal_done_d = 1'b0;
    cal_fail_d = 1'b0;
    case (state_d)
      ST_IDLE, ST_WAIT_READY, ST_SETTLE: bt_reset_d = 1'b1;
      ST_PATTERN, ST_TRAIN_RST: begin
        pat_en_d   = 1'b1;
        bt_reset_d = 1'b1;
      end
      ST_TRAIN: begin
        pat_en_d   = 1'b1;
        bt_start_d = 1'b1;
      end
      ST_ALIGN: begin
        pat_en_d   = 1'b1;
        bt_start_d = 1'b1;
        al_start_d = 1'b1;
      end
      ST_DONE: begin
        bt_start_d = 1'b1;
        al_start_d = 1'b1;
        cal_done_d = 1'b1;
      end
      ST_FAIL: begin
        bt_reset_d = 1'b1;
        cal_fail_d = 1'b1;
      end
      default: bt_reset_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      timer_q    <= 20'd0;
      retry_q    <= 4'd0;
      err_q      <= ERR_NONE;
      pat_en_q   <= 1'b0;
      bt_reset_q <= 1'b1;
      bt_start_q <= 1'b0;
      al_start_q <= 1'b0;
      cal_done_q <= 1'b0;
      cal_fail_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      retry_q    <= retry_d;
      err_q      <= err_d;
      pat_en_q   <= pat_en_d;
      bt_reset_q <= bt_reset_d;
      bt_start_q <= bt_start_d;
      al_start_q <= al_start_d;
      cal_done_q <= cal_done_d;
      cal_fail_q <= cal_fail_d;
    end
  end

  assign pat_en      = pat_en_q;
  assign bt_reset    = bt_reset_q;
  assign bt_start    = bt_start_q;
  assign al_start    = al_start_q;
  assign cal_done    = cal_done_q;
  assign cal_fail    = cal_fail_q;
  assign retry_count = retry_q;
  assign err_prb     = err_q;
  assign state_prb   = state_q;

endmodule

// File: tb/tb_qdrc_phy_cal_sequencer.sv
// Scoreboard bench: stimulus queues the expected state/output snapshot and dwell for each
// state change; a monitor compares every observed state change against the queue head.
module tb_qdrc_phy_cal_sequencer;

  localparam int SETTLE = 8;
  localparam int TMO    = 200;
  localparam int MAXR   = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       phy_ready = 1'b1;
  logic       cal_start = 1'b0;
  logic       pat_ack = 1'b0;
  logic       bt_done = 1'b0;
  logic       bt_fail = 1'b0;
  logic       al_done = 1'b0;
  logic       al_fail = 1'b0;
  logic       pat_en, bt_reset, bt_start, al_start, cal_done, cal_fail;
  logic [3:0] retry_count;
  logic [2:0] err_prb;
  logic [3:0] state_prb;

  qdrc_phy_cal_sequencer #(
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_CYCLES(TMO),
    .MAX_RETRY     (MAXR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .phy_ready  (phy_ready),
    .cal_start  (cal_start),
    .pat_en     (pat_en),
    .pat_ack    (pat_ack),
    .bt_reset   (bt_reset),
    .bt_start   (bt_start),
    .bt_done    (bt_done),
    .bt_fail    (bt_fail),
    .al_start   (al_start),
    .al_done    (al_done),
    .al_fail    (al_fail),
    .cal_done   (cal_done),
    .cal_fail   (cal_fail),
    .retry_count(retry_count),
    .err_prb    (err_prb),
    .state_prb  (state_prb)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pat_en;
    logic       bt_reset;
    logic       bt_start;
    logic       al_start;
    logic       cal_done;
    logic       cal_fail;
    logic [3:0] retry;
    logic [2:0] err;
  } snap_t;

  typedef struct {
    snap_t s;
    int    dwell;
  } exp_t;

  exp_t       sb_q[$];
  int         n_cmp = 0;
  int         n_fail = 0;
  int         cyc = 0;
  logic [3:0] mon_prev = 4'hF;
  int         mon_last = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output values each state must present, hand-written from the state table
  function automatic snap_t exp_snap(input int st, input int r, input int e);
    snap_t x;
    x = '0;
    x.st    = 4'(st);
    x.retry = 4'(r);
    x.err   = 3'(e);
    case (st)
      0, 1, 2: x.bt_reset = 1'b1;
      3, 4: begin x.pat_en = 1'b1; x.bt_reset = 1'b1; end
      5: begin x.pat_en = 1'b1; x.bt_start = 1'b1; end
      6: begin x.pat_en = 1'b1; x.bt_start = 1'b1; x.al_start = 1'b1; end
      7: begin x.cal_done = 1'b1; x.bt_start = 1'b1; x.al_start = 1'b1; end
      8: begin x.cal_fail = 1'b1; x.bt_reset = 1'b1; end
      default: x.bt_reset = 1'b1;
    endcase
    return x;
  endfunction

  function automatic string fmt(input snap_t s);
    return $sformatf("st=%0d pat_en=%b bt_reset=%b bt_start=%b al_start=%b cal_done=%b cal_fail=%b retry=%0d err=%0d",
                     s.st, s.pat_en, s.bt_reset, s.bt_start, s.al_start, s.cal_done, s.cal_fail, s.retry, s.err);
  endfunction

  task automatic push(input int st, input int r, input int e, input int dwell);
    exp_t x;
    x.s     = exp_snap(st, r, e);
    x.dwell = dwell;
    sb_q.push_back(x);
  endtask

  initial begin
    snap_t cur;
    exp_t  x;
    forever begin
      @(negedge clk);
      cur = '{state_prb, pat_en, bt_reset, bt_start, al_start, cal_done, cal_fail, retry_count, err_prb};
      if (cur.st != mon_prev) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_transition: got state %0d -> %0d at cycle %0d, required no transition",
                   mon_prev, cur.st, cyc);
        end else begin
          x = sb_q.pop_front();
          n_cmp++;
          if (cur !== x.s) begin
            n_fail++;
            $display("FAIL state%0d_outputs: got {%s} required {%s}", x.s.st, fmt(cur), fmt(x.s));
          end else begin
            $display("ok   cycle %0d enter {%s}", cyc, fmt(cur));
          end
          if (x.dwell >= 0) begin
            n_cmp++;
            if (cyc - mon_last != x.dwell) begin
              n_fail++;
              $display("FAIL dwell_before_state%0d: got %0d cycles required %0d", x.s.st, cyc - mon_last, x.dwell);
            end
          end
        end
        mon_last = cyc;
        mon_prev = cur.st;
      end
    end
  end

  task automatic finish_up();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  endtask

  task automatic wait_state(input int s, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (state_prb == 4'(s)) return;
    end
    n_cmp++;
    n_fail++;
    $display("FAIL wait_state%0d: got state %0d after %0d cycles, required %0d", s, state_prb, budget, s);
    finish_up();
  endtask

  // Called at the negedge after a state entry; drives so the DUT samples it n cycles after entry
  task automatic act_after(input int n);
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    cal_start = 1'b1;
    @(negedge clk);
    cal_start = 1'b0;
  endtask

  task automatic do_reset();
    push(0, 0, 0, -1);
    @(negedge clk);
    reset = 1'b1; cal_start = 1'b0; pat_ack = 1'b0;
    bt_done = 1'b0; bt_fail = 1'b0; al_done = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic push_front_end(input int pat_dwell);
    push(1, 0, 0, -1);
    push(2, 0, 0, 1);
    push(3, 0, 0, SETTLE);
    if (pat_dwell > 0) begin
      push(4, 0, 0, pat_dwell);
      push(5, 0, 0, 4);
    end
  endtask

  initial begin
    push(0, 0, 0, -1);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Nominal run, then phy_ready lost in DONE
    push_front_end(10);
    push(6, 0, 0, 50);
    push(7, 0, 0, 50);
    push(1, 0, 0, 4);
    pulse_start();
    wait_state(3, 50);  act_after(10); pat_ack = 1'b1;
    wait_state(5, 50);  act_after(50); bt_done = 1'b1;
    wait_state(6, 100); act_after(50); al_done = 1'b1;
    wait_state(7, 100); act_after(4);  phy_ready = 1'b0;
    wait_state(1, 10);
    pat_ack = 1'b1; bt_done = 1'b0; al_done = 1'b0;

    // phy_ready returns with pat_ack already high, then drops again during TRAIN
    push(2, 0, 0, 3);
    push(3, 0, 0, SETTLE);
    push(4, 0, 0, 1);
    push(5, 0, 0, 4);
    push(1, 0, 0, 6);
    act_after(3); phy_ready = 1'b1;
    wait_state(5, 50); act_after(6); phy_ready = 1'b0;
    wait_state(1, 10);

    // Two training failures then success
    push(2, 0, 0, 2);
    push(3, 0, 0, SETTLE);
    push(4, 0, 0, 1);
    push(5, 0, 0, 4);
    push(4, 1, 2, 7);
    push(5, 1, 2, 4);
    push(4, 2, 2, 7);
    push(5, 2, 2, 4);
    push(6, 2, 2, 7);
    push(7, 2, 2, 5);
    act_after(2); phy_ready = 1'b1;
    for (int a = 0; a < 2; a++) begin
      wait_state(5, 50); act_after(7); bt_done = 1'b1; bt_fail = 1'b1;
      wait_state(4, 10); bt_done = 1'b0; bt_fail = 1'b0;
    end
    wait_state(5, 10); act_after(7); bt_done = 1'b1;
    wait_state(6, 10); act_after(5); al_done = 1'b1;
    wait_state(7, 10);
    do_reset();

    // Retry exhaustion; FAIL ignores cal_start and phy_ready loss
    pat_ack = 1'b1;
    push_front_end(1);
    for (int r = 1; r <= MAXR; r++) begin
      push(4, r, 2, 3);
      push(5, r, 2, 4);
    end
    push(8, 3, 2, 3);
    pulse_start();
    for (int a = 0; a <= MAXR; a++) begin
      wait_state(5, 50); act_after(3); bt_done = 1'b1; bt_fail = 1'b1;
      if (a < MAXR) begin
        wait_state(4, 10); bt_done = 1'b0; bt_fail = 1'b0;
      end
    end
    wait_state(8, 10); bt_done = 1'b0; bt_fail = 1'b0;
    cal_start = 1'b1; repeat (3) @(negedge clk);
    cal_start = 1'b0; phy_ready = 1'b0; repeat (3) @(negedge clk);
    phy_ready = 1'b1; repeat (3) @(negedge clk);
    do_reset();

    // Pattern loop never acknowledges
    push_front_end(0);
    push(8, 0, 1, TMO);
    pulse_start();
    wait_state(8, 300);
    do_reset();

    // Bit trainer never finishes: every attempt times out
    pat_ack = 1'b1;
    push_front_end(1);
    for (int r = 1; r <= MAXR; r++) begin
      push(4, r, 3, TMO);
      push(5, r, 3, 4);
    end
    push(8, 3, 3, TMO);
    pulse_start();
    wait_state(8, 1500);
    do_reset();

    // bt_done on the timeout cycle wins; reset in ALIGN ignores simultaneous al_done
    pat_ack = 1'b1;
    push_front_end(1);
    push(6, 0, 0, TMO);
    push(0, 0, 0, 3);
    pulse_start();
    wait_state(5, 50); act_after(TMO); bt_done = 1'b1;
    wait_state(6, 10); act_after(3); reset = 1'b1; al_done = 1'b1;
    wait_state(0, 5);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    bt_done = 1'b0; al_done = 1'b0; pat_ack = 1'b0;
    repeat (5) @(negedge clk);

    n_cmp++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d expected transitions never seen, required 0", sb_q.size());
    end
    finish_up();
  end

endmodule
